// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: FSM encodings, control-bundle constants
// and the forwarding priority-encode helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_LU  = 2'd1,
    ST_MEM = 2'd2
  } hz_state_e;

  localparam int FWD_NONE    = 0;
  localparam int MAX_FWD_SRC = 32;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic bubble;
    logic freeze;
    logic if_flush;
    logic id_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_IDLE   = '{pc_en: 1'b1, if_id_en: 1'b1, bubble: 1'b0,
                                       freeze: 1'b0, if_flush: 1'b0, id_flush: 1'b0};
  localparam hz_ctrl_t CTRL_STALL  = '{pc_en: 1'b0, if_id_en: 1'b0, bubble: 1'b1,
                                       freeze: 1'b0, if_flush: 1'b0, id_flush: 1'b0};
  localparam hz_ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, bubble: 1'b0,
                                       freeze: 1'b1, if_flush: 1'b0, id_flush: 1'b0};
  localparam hz_ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, if_id_en: 1'b1, bubble: 1'b0,
                                       freeze: 1'b0, if_flush: 1'b1, id_flush: 1'b1};
  localparam hz_ctrl_t CTRL_JUMP   = '{pc_en: 1'b1, if_id_en: 1'b1, bubble: 1'b0,
                                       freeze: 1'b0, if_flush: 1'b1, id_flush: 1'b0};

  // Lowest hit index is the youngest producer; it maps to the highest code.
  function automatic int fwd_code(input logic [MAX_FWD_SRC-1:0] hit, input int num_src);
    int   code;
    logic found;
    code  = FWD_NONE;
    found = 1'b0;
    for (int i = 0; i < MAX_FWD_SRC; i++) begin
      if (!found && (i < num_src) && hit[i]) begin
        code  = num_src - i;
        found = 1'b1;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// One EX operand's bypass select: priority-encodes matching producers, youngest first.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int NUM_FWD_SRC = 2,
  parameter int FW          = $clog2(NUM_FWD_SRC + 1)
) (
  input  logic [REG_AW-1:0]             src_reg,
  input  logic [NUM_FWD_SRC*REG_AW-1:0] prod_rd,
  input  logic [NUM_FWD_SRC-1:0]        prod_we,
  output logic [FW-1:0]                 fwd_sel
);

  logic [MAX_FWD_SRC-1:0] hit_s;

  // Register 0 is hardwired, so a producer targeting it never forwards.
  always_comb begin
    hit_s = {MAX_FWD_SRC{1'b0}};
    for (int i = 0; i < NUM_FWD_SRC; i++) begin
      hit_s[i] = prod_we[i]
               && (prod_rd[i*REG_AW +: REG_AW] != {REG_AW{1'b0}})
               && (prod_rd[i*REG_AW +: REG_AW] == src_reg);
    end
  end

  assign fwd_sel = FW'(fwd_code(hit_s, NUM_FWD_SRC));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, memory freeze, bypass selects.
// Optional macro HAZ_PERF_CNT_EN adds saturating stall/flush/freeze performance counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int NUM_FWD_SRC  = 2,
  parameter int LOAD_USE_CYC = 1,
  parameter int CNT_W        = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [REG_AW-1:0]                    id_rs,
  input  logic [REG_AW-1:0]                    id_rt,
  input  logic                                 id_uses_rt,
  input  logic                                 id_j,
  input  logic                                 ex_memread,
  input  logic [REG_AW-1:0]                    ex_rs,
  input  logic [REG_AW-1:0]                    ex_rt,
  input  logic                                 ex_b,
  input  logic                                 ex_taken,
  input  logic                                 mem_busy,
  input  logic [NUM_FWD_SRC*REG_AW-1:0]        prod_rd,
  input  logic [NUM_FWD_SRC-1:0]               prod_we,
  output logic                                 pc_en,
  output logic                                 if_id_en,
  output logic                                 id_ex_bubble,
  output logic                                 pipe_freeze,
  output logic                                 if_flush,
  output logic                                 id_flush,
  output logic [$clog2(NUM_FWD_SRC+1)-1:0]     fwd_a,
  output logic [$clog2(NUM_FWD_SRC+1)-1:0]     fwd_b,
  output logic [CNT_W-1:0]                     stall_cnt,
  output logic [CNT_W-1:0]                     flush_cnt,
  output logic [CNT_W-1:0]                     freeze_cnt
);

  localparam int          FW      = $clog2(NUM_FWD_SRC + 1);
  localparam logic [3:0]  LU_INIT = 4'(LOAD_USE_CYC - 1);

  hz_state_e  state_q, state_d, run_state_s;
  logic [3:0] lu_cnt_q, lu_cnt_d, run_cnt_s;
  hz_ctrl_t   ctrl_s, run_ctrl_s;
  logic       lu_s, bt_s;

  hazard_fwd_sel #(.REG_AW(REG_AW), .NUM_FWD_SRC(NUM_FWD_SRC), .FW(FW)) u_fwd_a (
    .src_reg (ex_rs),
    .prod_rd (prod_rd),
    .prod_we (prod_we),
    .fwd_sel (fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW), .NUM_FWD_SRC(NUM_FWD_SRC), .FW(FW)) u_fwd_b (
    .src_reg (ex_rt),
    .prod_rd (prod_rd),
    .prod_we (prod_we),
    .fwd_sel (fwd_b)
  );

  assign lu_s = ex_memread && (ex_rt != {REG_AW{1'b0}})
             && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign bt_s = ex_b && ex_taken;

  // RUN decode, shared by RUN and the cycle MEM_WAIT releases.
  always_comb begin
    run_ctrl_s  = CTRL_IDLE;
    run_state_s = ST_RUN;
    run_cnt_s   = lu_cnt_q;
    if (mem_busy) begin
      run_ctrl_s  = CTRL_FREEZE;
      run_state_s = ST_MEM;
    end else if (bt_s) begin
      run_ctrl_s = CTRL_BRANCH;
    end else if (lu_s) begin
      run_ctrl_s = CTRL_STALL;
      if (LOAD_USE_CYC > 1) begin
        run_state_s = ST_LU;
        run_cnt_s   = LU_INIT;
      end else begin
        run_state_s = ST_RUN;
      end
    end else if (id_j) begin
      run_ctrl_s = CTRL_JUMP;
    end else begin
      run_ctrl_s = CTRL_IDLE;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    ctrl_s   = CTRL_IDLE;
    case (state_q)
      ST_RUN: begin
        ctrl_s   = run_ctrl_s;
        state_d  = run_state_s;
        lu_cnt_d = run_cnt_s;
      end
      ST_LU: begin
        if (mem_busy) begin
          ctrl_s = CTRL_FREEZE;
        end else begin
          ctrl_s = CTRL_STALL;
          if (lu_cnt_q <= 4'd1) begin
            state_d  = ST_RUN;
            lu_cnt_d = 4'd0;
          end else begin
            lu_cnt_d = lu_cnt_q - 4'd1;
          end
        end
      end
      ST_MEM: begin
        if (mem_busy) begin
          ctrl_s = CTRL_FREEZE;
        end else begin
          ctrl_s   = run_ctrl_s;
          state_d  = run_state_s;
          lu_cnt_d = run_cnt_s;
        end
      end
      default: begin
        state_d  = ST_RUN;
        lu_cnt_d = 4'd0;
      end
    endcase
  end

  // FSM state and load-use down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      lu_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign pc_en        = ctrl_s.pc_en;
  assign if_id_en     = ctrl_s.if_id_en;
  assign id_ex_bubble = ctrl_s.bubble;
  assign pipe_freeze  = ctrl_s.freeze;
  assign if_flush     = ctrl_s.if_flush;
  assign id_flush     = ctrl_s.id_flush;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (ctrl_s.bubble && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if ((ctrl_s.if_flush || ctrl_s.id_flush) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    if (ctrl_s.freeze && (freeze_cnt_q != {CNT_W{1'b1}})) begin
      freeze_cnt_d = freeze_cnt_q + CNT_ONE;
    end else begin
      freeze_cnt_d = freeze_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= {CNT_W{1'b0}};
      flush_cnt_q  <= {CNT_W{1'b0}};
      freeze_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`else
  assign stall_cnt  = {CNT_W{1'b0}};
  assign flush_cnt  = {CNT_W{1'b0}};
  assign freeze_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit (LOAD_USE_CYC = 3, two forwarding sources).
module tb_hazard_ctrl_unit;

  localparam int REG_AW = 5;
  localparam int NFS    = 2;
  localparam int LUC    = 3;
  localparam int CNT_W  = 32;

  // Expected control bundles: {pc_en, if_id_en, id_ex_bubble, pipe_freeze, if_flush, id_flush}
  localparam logic [5:0] C_IDLE  = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b001000;
  localparam logic [5:0] C_FRZ   = 6'b000100;
  localparam logic [5:0] C_BR    = 6'b110011;
  localparam logic [5:0] C_J     = 6'b110010;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] EXP_STALL_LU  = 32'd3;
  localparam logic [CNT_W-1:0] EXP_STALL_FRZ = 32'd6;
  localparam logic [CNT_W-1:0] EXP_FRZ_FRZ   = 32'd4;
`else
  localparam logic [CNT_W-1:0] EXP_STALL_LU  = 32'd0;
  localparam logic [CNT_W-1:0] EXP_STALL_FRZ = 32'd0;
  localparam logic [CNT_W-1:0] EXP_FRZ_FRZ   = 32'd0;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [REG_AW-1:0]       id_rs, id_rt, ex_rs, ex_rt;
  logic                    id_uses_rt, id_j, ex_memread, ex_b, ex_taken, mem_busy;
  logic [NFS*REG_AW-1:0]   prod_rd;
  logic [NFS-1:0]          prod_we;
  logic                    pc_en, if_id_en, id_ex_bubble, pipe_freeze, if_flush, id_flush;
  logic [1:0]              fwd_a, fwd_b;
  logic [CNT_W-1:0]        stall_cnt, flush_cnt, freeze_cnt;
  logic [5:0]              ctl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_en, if_id_en, id_ex_bubble, pipe_freeze, if_flush, id_flush};

  hazard_ctrl_unit #(.REG_AW(REG_AW), .NUM_FWD_SRC(NFS), .LOAD_USE_CYC(LUC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_j(id_j), .ex_memread(ex_memread), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_b(ex_b),
    .ex_taken(ex_taken), .mem_busy(mem_busy), .prod_rd(prod_rd), .prod_we(prod_we),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
    .if_flush(if_flush), .id_flush(id_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_j = 1'b0; ex_memread = 1'b0;
    ex_b = 1'b0; ex_taken = 1'b0; mem_busy = 1'b0;
    prod_rd = 10'd0; prod_we = 2'b00;
  endtask

  task automatic set_lu();
    ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
  endtask

  task automatic test_reset();
    clear_inputs();
    #3;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_IDLE); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || freeze_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, freeze_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL post_reset_ctl: got %b expected %b", ctl, C_IDLE); end
  endtask

  task automatic test_fwd();
    prod_rd = {5'd8, 5'd8}; prod_we = 2'b11; ex_rs = 5'd8; ex_rt = 5'd8;
    #1;
    checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_a_youngest: got %b expected 10", fwd_a); end
    checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_b_youngest: got %b expected 10", fwd_b); end
    prod_we = 2'b10;
    #1;
    checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_a_older: got %b expected 01", fwd_a); end
    prod_rd = {5'd8, 5'd3}; prod_we = 2'b11; ex_rt = 5'd3;
    #1;
    checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b10) begin
      errors++; $display("FAIL fwd_split: got a=%b b=%b expected a=01 b=10", fwd_a, fwd_b);
    end
    ex_rs = 5'd0; prod_rd = 10'd0;
    #1;
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_r0: got %b expected 00", fwd_a); end
    clear_inputs();
  endtask

  task automatic test_lu_masked();
    tick();
    ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0; id_rs = 5'd4;
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_rt_unused: got %b expected %b", ctl, C_IDLE); end
    id_uses_rt = 1'b1;
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL lu_rt_used: got %b expected %b", ctl, C_STALL); end
    id_uses_rt = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_r0: got %b expected %b", ctl, C_IDLE); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    tick();
    set_lu();
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (ctl !== ((c < 3) ? C_STALL : C_IDLE)) begin
        errors++; $display("FAIL lu_cycle%0d: got %b expected %b", c, ctl, (c < 3) ? C_STALL : C_IDLE);
      end
      tick();
      if (c == 0) begin
        ex_memread = 1'b0; ex_rt = 5'd0;
      end
    end
    checks++; if (stall_cnt !== EXP_STALL_LU) begin
      errors++; $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, EXP_STALL_LU);
    end
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    set_lu(); ex_b = 1'b1; ex_taken = 1'b1;
    #1;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_over_lu: got %b expected %b", ctl, C_BR); end
    tick();
    clear_inputs();
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL br_stays_run: got %b expected %b", ctl, C_IDLE); end
    id_j = 1'b1;
    #1;
    checks++; if (ctl !== C_J) begin errors++; $display("FAIL jump_alone: got %b expected %b", ctl, C_J); end
    set_lu();
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL lu_over_jump: got %b expected %b", ctl, C_STALL); end
    clear_inputs();
  endtask

  task automatic test_freeze_in_stall();
    tick();
    set_lu();
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL frz_first_bubble: got %b expected %b", ctl, C_STALL); end
    tick();
    ex_memread = 1'b0; ex_rt = 5'd0; mem_busy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL frz_cycle%0d: got %b expected %b", c, ctl, C_FRZ); end
      tick();
    end
    mem_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (ctl !== ((c < 2) ? C_STALL : C_IDLE)) begin
        errors++; $display("FAIL frz_resume%0d: got %b expected %b", c, ctl, (c < 2) ? C_STALL : C_IDLE);
      end
      tick();
    end
    checks++; if (stall_cnt !== EXP_STALL_FRZ || freeze_cnt !== EXP_FRZ_FRZ) begin
      errors++; $display("FAIL frz_counters: got stall=%0d freeze=%0d expected stall=%0d freeze=%0d",
                         stall_cnt, freeze_cnt, EXP_STALL_FRZ, EXP_FRZ_FRZ);
    end
    clear_inputs();
  endtask

  task automatic test_branch_after_freeze();
    mem_busy = 1'b1; ex_b = 1'b1; ex_taken = 1'b1;
    #1;
    checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL brfrz_run: got %b expected %b", ctl, C_FRZ); end
    tick();
    #1;
    checks++; if (ctl !== C_FRZ) begin errors++; $display("FAIL brfrz_wait: got %b expected %b", ctl, C_FRZ); end
    tick();
    mem_busy = 1'b0;
    #1;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL brfrz_release: got %b expected %b", ctl, C_BR); end
    tick();
    clear_inputs();
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL brfrz_after: got %b expected %b", ctl, C_IDLE); end
  endtask

  task automatic test_async_reset();
    tick();
    set_lu();
    tick();
    ex_memread = 1'b0; ex_rt = 5'd0;
    #1;
    checks++; if (ctl !== C_STALL) begin errors++; $display("FAIL ar_in_stall: got %b expected %b", ctl, C_STALL); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL ar_immediate: got %b expected %b", ctl, C_IDLE); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || freeze_cnt !== 32'd0) begin
      errors++; $display("FAIL ar_counters: got %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, freeze_cnt);
    end
    #1;
    reset = 1'b0;
    tick();
    #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL ar_after: got %b expected %b", ctl, C_IDLE); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fwd();
    test_lu_masked();
    test_load_use();
    test_branch_priority();
    test_freeze_in_stall();
    test_branch_after_freeze();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
